// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default reset PC and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries. Flush wins over push and pop;
// storage is left unreset because the occupancy count qualifies every read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_instr,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full buffer overwrites the head slot only when that head
  // is leaving on the same edge, so the combinational read stays correct.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, drives the instruction memory address,
// buffers returned words with their PC and handles redirects.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready,
  output logic                  misalign_err
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;

  assign imem_addr = fetch_pc;
  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? head_pc : '0;
  assign out_instr = out_valid ? head_instr : '0;

  // IDLE fetches on the same cycle fetch_en first rises, so only ERR blocks.
  assign pop  = out_valid && out_ready;
  assign push = (state != ERR) && fetch_en && !redirect_valid &&
                (!fifo_full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state        <= ERR;
        misalign_err <= 1'b1;
      end else begin
        state        <= RUN;
        fetch_pc     <= redirect_pc;
        misalign_err <= 1'b0;
      end
    end else begin
      if (state == IDLE && fetch_en) state <= RUN;
      if (push) fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INCR);
    end
  end

  fetch_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (fetch_pc),
    .push_instr (imem_instr),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then random traffic, all
// checked against a queue-based reference model of the fetch buffer.
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending entries, next fetch address, error flag.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_err;

  always #5 clk = ~clk;

  // Memory word n holds n.
  assign imem_instr = {2'b00, imem_addr[31:2]};

  instr_fetch_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    ev  = (m_q.size() != 0);
    epc = ev ? m_q[0][63:32] : 32'h0;
    ein = ev ? m_q[0][31:0]  : 32'h0;
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ev});
    chk({tag, ".out_pc"}, out_pc, epc);
    chk({tag, ".out_instr"}, out_instr, ein);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc  = 32'h0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    pop = (m_q.size() != 0) && rdy;
    if (rv) begin
      m_q.delete();
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
      else begin
        m_pc  = rpc;
        m_err = 1'b0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_err && fe && m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, 2'b00, m_pc[31:2]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Entered and left at a falling edge: check, drive, advance the model.
  task automatic cycle(input string tag, input bit fe, input bit rv,
                       input logic [31:0] rpc, input bit rdy);
    check_model(tag);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(fe, rv, rpc, rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    bit          fe, rv, rdy;

    reset = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk("rst.misalign", {31'b0, misalign_err}, 32'h0);
    reset = 1'b0;

    // Idle without fetch_en, then stream at full rate.
    cycle("idle", 0, 0, 0, 1);
    cycle("idle", 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle("stream", 1, 0, 0, 1);
    chk("stream.out_pc", out_pc, 32'd28);
    chk("stream.out_instr", out_instr, 32'd7);

    // Fresh start, then stall decode for five cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) cycle("stall", 1, 0, 0, 0);
    chk("stall.imem_addr", imem_addr, 32'h8);
    chk("stall.out_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) cycle("release", 1, 0, 0, 1);

    // Fill, then redirect while full with out_ready high.
    for (int i = 0; i < 3; i++) cycle("fill", 1, 0, 0, 0);
    cycle("redir40", 1, 1, 32'h40, 1);
    chk("redir40.out_valid", {31'b0, out_valid}, 32'h0);
    chk("redir40.imem_addr", imem_addr, 32'h40);
    cycle("redir40b", 1, 0, 0, 1);
    chk("redir40.first_pc", out_pc, 32'h40);
    for (int i = 0; i < 3; i++) cycle("after40", 1, 0, 0, 1);

    // Misaligned target, recovery at 0x80.
    cycle("redir42", 1, 1, 32'h42, 1);
    chk("redir42.misalign", {31'b0, misalign_err}, 32'h1);
    for (int i = 0; i < 4; i++) cycle("err", 1, 0, 0, 1);
    chk("err.out_valid", {31'b0, out_valid}, 32'h0);
    cycle("redir80", 1, 1, 32'h80, 1);
    chk("redir80.misalign", {31'b0, misalign_err}, 32'h0);
    cycle("redir80b", 1, 0, 0, 1);
    chk("redir80.first_pc", out_pc, 32'h80);

    // Wrap-around at the top of the address space.
    cycle("redirwrap", 1, 1, 32'hFFFF_FFFC, 1);
    cycle("wrap", 1, 0, 0, 1);
    chk("wrap.pc_top", out_pc, 32'hFFFF_FFFC);
    cycle("wrap", 1, 0, 0, 1);
    chk("wrap.pc_zero", out_pc, 32'h0);
    chk("wrap.instr_zero", out_instr, 32'h0);

    // fetch_en low in RUN: PC holds while the buffer drains.
    for (int i = 0; i < 2; i++) cycle("fe0fill", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("fe0drain", 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      fe  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      else if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
      cycle("rand", fe, rv, rpc, rdy);
    end

    // Asynchronous reset mid-stream with the buffer full.
    cycle("prefill", 1, 1, 32'h100, 1);
    for (int i = 0; i < 3; i++) cycle("prefill", 1, 0, 0, 0);
    chk("prefill.imem_addr", imem_addr, 32'h108);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst.out_pc", out_pc, 32'h0);
    chk("arst.out_instr", out_instr, 32'h0);
    chk("arst.imem_addr", imem_addr, 32'h0);
    chk("arst.misalign", {31'b0, misalign_err}, 32'h0);
    fetch_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_rst_idle", 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle("post_rst_run", 1, 0, 0, 1);
    check_model("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch controller that sequences the combinational-read instruction memory for the RISC-V core. It owns the fetch program counter and drives the memory word address every cycle. Each returned instruction is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles branch/jump redirects and flags misaligned redirect targets.

## Interface
- ADDR_WIDTH, 32, byte-address width of PC and memory address
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch buffer entries; legal values are 2 and 4
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- fetch_en  input  1  permits new fetches; low freezes PC, buffer still drains
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory (memory uses bits [31:2])
- imem_instr  input  DATA_WIDTH  instruction returned combinationally for imem_addr
- redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  input  ADDR_WIDTH  new fetch address
- out_valid  output  1  buffer head holds an instruction
- out_instr  output  DATA_WIDTH  head instruction
- out_pc  output  ADDR_WIDTH  PC of head instruction
- out_ready  input  1  decode accepts head this cycle
- misalign_err  output  1  sticky: last redirect target had bits [1:0] != 0

## Operation
- State machine with three states:
  - IDLE (after reset): no fetches. Go to RUN on the first cycle fetch_en=1; that cycle already fetches.
  - RUN: fetches are permitted.
  - ERR: no fetches; misalign_err=1.
- imem_addr = fetch_pc combinationally in every state.
- Push condition, all of: state RUN; fetch_en=1; no redirect_valid; and either buffer not full, or buffer full with out_ready=1 and out_valid=1 in the same cycle.
- On push: the entry {fetch_pc, imem_instr} is written at the tail and fetch_pc <= fetch_pc + 4.
- Pop: head is removed when out_valid && out_ready.
- Push and pop in the same cycle are legal at any occupancy; the count is unchanged.
- Redirect, when redirect_valid=1:
  - Buffer is flushed (count <= 0). Any simultaneous pop and push are discarded.
  - Aligned redirect_pc: fetch_pc <= redirect_pc, state <= RUN (from IDLE, RUN or ERR), misalign_err <= 0.
  - Misaligned redirect_pc[1:0] != 0: fetch_pc unchanged, state <= ERR, misalign_err <= 1.
- PC arithmetic is modulo 2^ADDR_WIDTH: fetch_pc 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- fetch_en=0 in RUN: PC holds, no push, existing entries still pop normally.
- Reset at any time, including mid-redirect or with the buffer full:
  - fetch_pc = RESET_PC, state = IDLE, count = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
- out_instr and out_pc read as 0 whenever out_valid = 0.

## Timing
- Fetch to output latency is 1 cycle: an instruction pushed at edge N is on the outputs with out_valid=1 after edge N.
- Sustained throughput is 1 instruction/cycle while out_ready=1 and fetch_en=1.
- Redirect pulse in cycle N:
  - out_valid=0 in cycle N+1.
  - imem_addr = redirect_pc in cycle N+1.
  - First new instruction is valid in cycle N+2.
- out_valid, out_instr and out_pc are stable while out_valid=1 and out_ready=0 (standard valid/ready hold rule).
- No combinational path from out_ready to imem_addr. out_ready affects only whether a push may occur into a full buffer.

## Structure
- Shared package fetch_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, ERR=2'd2);
  - the default RESET_PC;
  - the PC increment constant 4.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} entries with depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty.
  - Flush has priority over push and pop.
  - Pointers wrap at FIFO_DEPTH.
- The top level holds fetch_pc, the FSM, misalign_err and the push/pop qualification.

## Test plan
- Reset release, fetch_en=1, out_ready=1, memory word n = n:
  - out_valid first high the cycle after the first fetch;
  - out_pc 0,4,8,… with out_instr 0,1,2,… one per cycle.
- out_ready=0 for 5 cycles with FIFO_DEPTH=2:
  - exactly 2 entries held and imem_addr frozen at 8;
  - out_pc stays 0 while held;
  - on release the sequence continues with 0,4,8 and no gaps or duplicates.
- Redirect to 32'h40 while the buffer is full and out_ready=1:
  - next cycle out_valid=0 and imem_addr=32'h40;
  - the cycle after, out_pc=32'h40.
- Redirect to 32'h42:
  - misalign_err=1, state ERR, no further out_valid;
  - a subsequent redirect to 32'h80 clears the error and resumes at 32'h80.
- Redirect to 32'hFFFF_FFFC: out_pc FFFF_FFFC then 0 (wrap-around).
- Assert reset asynchronously mid-stream with the buffer full:
  - all outputs 0 immediately, imem_addr=RESET_PC;
  - no fetch until fetch_en=1.
